// File: rtl/wb_timer_pkg.sv
// wb_timer_pkg: shared definitions for the Wishbone timer.
//   - register index map (word offset, i_wb_addr[4:2])
//   - CTRL bit positions and width
//   - apply_sel(): byte-lane merge used by every register write
package wb_timer_pkg;

    localparam int unsigned REG_AW = 3;

    localparam logic [REG_AW-1:0] REG_CTRL   = 3'd0;
    localparam logic [REG_AW-1:0] REG_PRESC  = 3'd1;
    localparam logic [REG_AW-1:0] REG_LOAD   = 3'd2;
    localparam logic [REG_AW-1:0] REG_COUNT  = 3'd3;
    localparam logic [REG_AW-1:0] REG_CMP    = 3'd4;
    localparam logic [REG_AW-1:0] REG_STATUS = 3'd5;

    localparam int unsigned CTRL_W  = 3;
    localparam int unsigned CTRL_EN = 0;
    localparam int unsigned CTRL_AR = 1;
    localparam int unsigned CTRL_IE = 2;

    // Replace only the bytes whose enable is set.
    function automatic logic [31:0] apply_sel(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// wb_timer_prescaler: divides the system clock for the timer counter.
//   While enabled, an internal count runs 0..presc_i and tick_o is high
//   during the cycle where the count equals presc_i, so a tick occurs every
//   presc_i+1 cycles (presc_i = 0 ticks every cycle). Disabled holds the
//   count at 0, so the first tick after enabling is always a full period away.
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   en_i     in   prescaler enable (CTRL.EN)
//   presc_i  in   W-bit divide value
//   tick_o   out  one-cycle tick, combinational from the count flops
module wb_timer_prescaler #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [W-1:0] presc_i,
    output logic         tick_o
);

    logic [W-1:0] pcnt_q;
    logic [W-1:0] pcnt_d;

    assign tick_o = en_i && (pcnt_q == presc_i);

    always_comb begin
        pcnt_d = pcnt_q + 1'b1;
        if (!en_i || tick_o) begin
            pcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/wb_timer.sv
// wb_timer: Wishbone-B4 classic slave, 32-bit down-counter timer with IRQ.
//   Registers (word offset = i_wb_addr[4:2]):
//     0 CTRL  {[2]IE, [1]AR auto-reload, [0]EN}
//     1 PRESC prescaler divide value
//     2 LOAD  auto-reload value
//     3 COUNT current count (R/W)
//     4 CMP   PWM compare (only with WB_TIMER_PWM_EN, else reads 0)
//     5 STATUS {[0]PEND}, write 1 to clear
//     6,7     read 0, writes ignored
//   Optional feature macro: WB_TIMER_PWM_EN adds CMP and the o_pwm port.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   i_wb_cyc/stb/we/addr/data/sel  Wishbone request
//   o_wb_stall                 always 0
//   o_wb_ack, o_wb_data        one-cycle ack with registered read data
//   o_irq                      PEND & CTRL.IE (combinational from flops)
//   i_eoi                      end-of-interrupt pulse, clears PEND
//   o_pwm                      EN & (COUNT < CMP), registered (macro only)
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter int unsigned PRESC_W  = 16,
    parameter logic [31:0] RST_LOAD = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_stall,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    output logic        o_irq,
    input  logic        i_eoi
`ifdef WB_TIMER_PWM_EN
    ,
    output logic        o_pwm
`endif
);

    logic [CTRL_W-1:0]  ctrl_q,  ctrl_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [31:0]        load_q,  load_d;
    logic [31:0]        count_q, count_d;
    logic               pend_q,  pend_d;
    logic               ack_q,   ack_d;
    logic [31:0]        rdata_q, rdata_d;
`ifdef WB_TIMER_PWM_EN
    logic [31:0]        cmp_q,   cmp_d;
    logic               pwm_q,   pwm_d;
`endif

    logic [REG_AW-1:0]  reg_idx;
    logic               accept;
    logic               wr_acc;
    logic               tick;
    logic               underflow;
    logic [31:0]        reg_rd;
    logic [31:0]        wr_val;
    logic               unused_addr;

    // Bus handshake: a request is taken when cyc & stb are high and no ack
    // is currently being driven; the ack follows one cycle later and lasts
    // one cycle, which also blocks the next accept (no back-to-back acks).
    // Register side effects happen at the accept edge. The ack is masked by
    // cyc so a master that abandons the cycle never sees it.
    assign reg_idx     = i_wb_addr[4:2];
    assign accept      = i_wb_cyc && i_wb_stb && !ack_q;
    assign wr_acc      = accept && i_wb_we;
    assign unused_addr = ^{i_wb_addr[31:5], i_wb_addr[1:0]};

    assign o_wb_stall = 1'b0;
    assign o_wb_ack   = ack_q && i_wb_cyc;
    assign o_wb_data  = rdata_q;
    assign o_irq      = pend_q && ctrl_q[CTRL_IE];
`ifdef WB_TIMER_PWM_EN
    assign o_pwm      = pwm_q;
`endif

    wb_timer_prescaler #(.W(PRESC_W)) u_presc (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (ctrl_q[CTRL_EN]),
        .presc_i (presc_q),
        .tick_o  (tick)
    );

    assign underflow = tick && (count_q == 32'd0);

    // Read mux; also supplies the old value for byte-masked writes.
    always_comb begin
        reg_rd = 32'd0;
        case (reg_idx)
            REG_CTRL:   reg_rd = 32'(ctrl_q);
            REG_PRESC:  reg_rd = 32'(presc_q);
            REG_LOAD:   reg_rd = load_q;
            REG_COUNT:  reg_rd = count_q;
`ifdef WB_TIMER_PWM_EN
            REG_CMP:    reg_rd = cmp_q;
`endif
            REG_STATUS: reg_rd = {31'd0, pend_q};
            default:    reg_rd = 32'd0;
        endcase
    end

    assign wr_val = apply_sel(reg_rd, i_wb_data, i_wb_sel);

    always_comb begin
        ctrl_d  = ctrl_q;
        presc_d = presc_q;
        load_d  = load_q;
        count_d = count_q;
        pend_d  = pend_q;
`ifdef WB_TIMER_PWM_EN
        cmp_d   = cmp_q;
        pwm_d   = ctrl_q[CTRL_EN] && (count_q < cmp_q);
`endif
        ack_d   = accept;
        rdata_d = (accept && !i_wb_we) ? reg_rd : 32'd0;

        // Tick update: count down, and at zero raise PEND and either reload
        // or stop (one-shot). The count never wraps below zero.
        if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else if (ctrl_q[CTRL_AR]) begin
                count_d = load_q;
            end else begin
                ctrl_d[CTRL_EN] = 1'b0;
            end
        end

        if (i_eoi) begin
            pend_d = 1'b0;
        end
        if (wr_acc && (reg_idx == REG_STATUS) && i_wb_sel[0] && i_wb_data[0]) begin
            pend_d = 1'b0;
        end
        // A fresh underflow must not be lost to a simultaneous clear.
        if (underflow) begin
            pend_d = 1'b1;
        end

        // Software writes take precedence over the tick update above.
        if (wr_acc) begin
            case (reg_idx)
                REG_CTRL:  ctrl_d  = wr_val[CTRL_W-1:0];
                REG_PRESC: presc_d = wr_val[PRESC_W-1:0];
                REG_LOAD:  load_d  = wr_val;
                REG_COUNT: count_d = wr_val;
`ifdef WB_TIMER_PWM_EN
                REG_CMP:   cmp_d   = wr_val;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            presc_q <= '0;
            load_q  <= RST_LOAD;
            count_q <= 32'd0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= 32'd0;
`ifdef WB_TIMER_PWM_EN
            cmp_q   <= 32'd0;
            pwm_q   <= 1'b0;
`endif
        end else begin
            ctrl_q  <= ctrl_d;
            presc_q <= presc_d;
            load_q  <= load_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
`ifdef WB_TIMER_PWM_EN
            cmp_q   <= cmp_d;
            pwm_q   <= pwm_d;
`endif
        end
    end

endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: self-checking bench for wb_timer.
// Timing reference: every bus task returns 1 time unit after the edge on
// which the DUT accepted the request ("sample point"). Timer expectations
// are derived arithmetically: with divide p, ticks land on edges
// (p+1), 2(p+1), ...; starting from COUNT=c the first underflow is on edge
// (c+1)(p+1) after EN is set and then every (LOAD+1)(p+1) edges.
module tb_wb_timer;

    localparam logic [2:0] R_CTRL   = 3'd0;
    localparam logic [2:0] R_PRESC  = 3'd1;
    localparam logic [2:0] R_LOAD   = 3'd2;
    localparam logic [2:0] R_COUNT  = 3'd3;
    localparam logic [2:0] R_CMP    = 3'd4;
    localparam logic [2:0] R_STATUS = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_wb_cyc, i_wb_stb, i_wb_we;
    logic [31:0] i_wb_addr, i_wb_data;
    logic [3:0]  i_wb_sel;
    logic        o_wb_stall, o_wb_ack, o_irq, i_eoi;
    logic [31:0] o_wb_data;
`ifdef WB_TIMER_PWM_EN
    logic        o_pwm;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    wb_timer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wb_cyc   (i_wb_cyc),
        .i_wb_stb   (i_wb_stb),
        .i_wb_we    (i_wb_we),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .i_wb_sel   (i_wb_sel),
        .o_wb_stall (o_wb_stall),
        .o_wb_ack   (o_wb_ack),
        .o_wb_data  (o_wb_data),
        .o_irq      (o_irq),
        .i_eoi      (i_eoi)
`ifdef WB_TIMER_PWM_EN
        ,
        .o_pwm      (o_pwm)
`endif
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic bus_op(input logic we, input logic [2:0] idx, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd);
        logic [31:0] r;
        int n;
        r = $urandom();
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = we;
        i_wb_addr = {r[31:5], idx, r[1:0]};  // undecoded bits randomised
        i_wb_data = d;
        i_wb_sel  = s;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (o_wb_ack !== 1'b1 && n < 8);
        total++;
        if (o_wb_ack !== 1'b1) begin
            bad++;
            $display("FAIL bus_ack idx=%0d we=%b got=%b want=1", idx, we, o_wb_ack);
        end
        rd = o_wb_data;
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
    endtask

    task automatic wb_write(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        bus_op(1'b1, idx, d, s, dummy);
    endtask

    task automatic wb_read(input logic [2:0] idx, output logic [31:0] d);
        bus_op(1'b0, idx, 32'd0, 4'hF, d);
    endtask

    task automatic stop_and_clear();
        wb_write(R_CTRL, 32'd0, 4'hF);
        wb_write(R_STATUS, 32'd1, 4'hF);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] d;
        total++;
        if (o_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", o_irq); end
        total++;
        if (o_wb_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", o_wb_stall); end
        total++;
        if (o_wb_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", o_wb_ack); end
        for (int i = 0; i < 8; i++) begin
            wb_read(i[2:0], d);
            total++;
            if (d !== 32'd0) begin bad++; $display("FAIL reset_read idx=%0d got=%h want=0", i, d); end
        end
    endtask

    task automatic test_back_to_back();
        logic want;
        @(posedge clk); #1;  // idle cycle so no ack is pending
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0;
        i_wb_addr = {27'd0, R_LOAD, 2'b00}; i_wb_sel = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            want = (k % 2) == 1;
            total++;
            if (o_wb_ack !== want) begin
                bad++; $display("FAIL b2b_ack k=%0d got=%b want=%b", k, o_wb_ack, want);
            end
        end
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_cyc_drop();
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0;
        i_wb_addr = {27'd0, R_CTRL, 2'b00}; i_wb_sel = 4'hF;
        @(posedge clk); #1;  // accepted here
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        #1;
        total++;
        if (o_wb_ack !== 1'b0) begin bad++; $display("FAIL cyc_drop_ack got=%b want=0", o_wb_ack); end
        @(posedge clk); #1;
        total++;
        if (o_wb_ack !== 1'b0) begin bad++; $display("FAIL cyc_drop_ack2 got=%b want=0", o_wb_ack); end
    endtask

    task automatic test_sel();
        logic [31:0] d;
        wb_write(R_LOAD, 32'd0, 4'hF);
        wb_write(R_LOAD, 32'hAABBCCDD, 4'b0010);
        wb_read(R_LOAD, d);
        total++;
        if (d !== 32'h0000CC00) begin bad++; $display("FAIL sel_load got=%h want=0000cc00", d); end
    endtask

    // Random byte-masked writes with the timer stopped, checked against a
    // register image kept in the bench.
    task automatic test_random_regs();
        logic [31:0] img [8];
        logic [31:0] d, m, got, want;
        logic [2:0]  idx, ridx;
        logic [3:0]  s;
        stop_and_clear();
        for (int i = 0; i < 8; i++) begin
            wb_write(i[2:0], 32'd0, 4'hF);
            img[i] = 32'd0;
        end
        for (int n = 0; n < 24; n++) begin
            idx = 3'($urandom_range(0, 7));
            d   = $urandom();
            s   = 4'($urandom_range(0, 15));
            if (idx == R_CTRL) d[0] = 1'b0;  // keep the timer stopped
            wb_write(idx, d, s);
            m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
            case (idx)
                R_CTRL:  img[0] = ((img[0] & ~m) | (d & m)) & 32'h7;
                R_PRESC: img[1] = ((img[1] & ~m) | (d & m)) & 32'hFFFF;
                R_LOAD:  img[2] = (img[2] & ~m) | (d & m);
                R_COUNT: img[3] = (img[3] & ~m) | (d & m);
`ifdef WB_TIMER_PWM_EN
                R_CMP:   img[4] = (img[4] & ~m) | (d & m);
`endif
                default: ;
            endcase
            ridx = 3'($urandom_range(0, 7));
            exp_q.push_back(img[ridx]);
            wb_read(ridx, got);
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++; $display("FAIL reg_rw idx=%0d got=%h want=%h", ridx, got, want);
            end
        end
    endtask

    // Auto-reload run; EOI is pulsed in every cycle the model expects IRQ,
    // so IRQ must be high exactly on underflow edges.
    task automatic run_periodic(input int p, input int l, input int c, input int periods);
        int   first, per;
        logic exp_irq;
        stop_and_clear();
        wb_write(R_PRESC, 32'(p), 4'hF);
        wb_write(R_LOAD,  32'(l), 4'hF);
        wb_write(R_COUNT, 32'(c), 4'hF);
        wb_write(R_CTRL,  32'h7,  4'hF);  // EN set on this accept edge = edge 0
        first = (c + 1) * (p + 1);
        per   = (l + 1) * (p + 1);
        for (int k = 1; k <= first + periods * per; k++) begin
            @(posedge clk); #1;
            exp_irq = (k >= first) && (((k - first) % per) == 0);
            total++;
            if (o_irq !== exp_irq) begin
                bad++;
                $display("FAIL periodic_irq p=%0d l=%0d c=%0d k=%0d got=%b want=%b",
                         p, l, c, k, o_irq, exp_irq);
            end
            i_eoi = exp_irq;
        end
        i_eoi = 1'b0;
        stop_and_clear();
    endtask

    task automatic test_autoreload();
        run_periodic(0, 3, 3, 2);
    endtask

    task automatic test_random_periodic();
        int p, l, c;
        for (int it = 0; it < 6; it++) begin
            p = $urandom_range(0, 3);
            l = $urandom_range(0, 4);
            c = $urandom_range(0, 4);
            run_periodic(p, l, c, 2);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        logic        want;
        stop_and_clear();
        wb_write(R_PRESC, 32'd9, 4'hF);
        wb_write(R_COUNT, 32'd1, 4'hF);
        wb_write(R_CTRL,  32'h5, 4'hF);
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            want = (k >= 20);
            total++;
            if (o_irq !== want) begin
                bad++; $display("FAIL oneshot_irq k=%0d got=%b want=%b", k, o_irq, want);
            end
        end
        wb_read(R_CTRL, d);
        total++;
        if (d !== 32'h4) begin bad++; $display("FAIL oneshot_ctrl got=%h want=4", d); end
        wb_read(R_COUNT, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL oneshot_count got=%h want=0", d); end
        wb_read(R_STATUS, d);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL oneshot_pend got=%h want=1", d); end
    endtask

    task automatic test_clear();
        // PEND still set from the one-shot run; W1C must drop IRQ at once.
        wb_write(R_STATUS, 32'd1, 4'hF);
        total++;
        if (o_irq !== 1'b0) begin bad++; $display("FAIL w1c_irq got=%b want=0", o_irq); end
        // Immediate one-shot underflow, then clear through EOI.
        wb_write(R_PRESC, 32'd0, 4'hF);
        wb_write(R_COUNT, 32'd0, 4'hF);
        wb_write(R_CTRL,  32'h5, 4'hF);
        @(posedge clk); #1;
        total++;
        if (o_irq !== 1'b1) begin bad++; $display("FAIL eoi_pre_irq got=%b want=1", o_irq); end
        i_eoi = 1'b1;
        @(posedge clk); #1;
        i_eoi = 1'b0;
        total++;
        if (o_irq !== 1'b0) begin bad++; $display("FAIL eoi_irq got=%b want=0", o_irq); end
    endtask

    task automatic test_collisions();
        logic [31:0] d;
        stop_and_clear();
        wb_write(R_PRESC, 32'd0, 4'hF);
        wb_write(R_COUNT, 32'h1000, 4'hF);
        wb_write(R_CTRL,  32'h1, 4'hF);    // ticking every cycle
        wb_write(R_COUNT, 32'h55, 4'hF);   // lands on a tick edge
        wb_read(R_COUNT, d);
        // The read is accepted two edges after the write; exactly one more
        // tick has decremented the written value by then.
        total++;
        if (d !== 32'h54) begin bad++; $display("FAIL tick_vs_write got=%h want=54", d); end
        // LOAD=0 with AR underflows every tick; EOI every cycle must lose.
        run_periodic(0, 0, 0, 6);
    endtask

`ifdef WB_TIMER_PWM_EN
    task automatic test_pwm();
        int highs;
        stop_and_clear();
        wb_write(R_PRESC, 32'd0, 4'hF);
        wb_write(R_LOAD,  32'd9, 4'hF);
        wb_write(R_CMP,   32'd3, 4'hF);
        wb_write(R_COUNT, 32'd9, 4'hF);
        wb_write(R_CTRL,  32'h3, 4'hF);
        repeat (5) @(posedge clk);
        #1;
        highs = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (o_pwm === 1'b1) highs++;
        end
        total++;
        if (highs != 12) begin bad++; $display("FAIL pwm_duty got=%0d want=12", highs); end
        stop_and_clear();
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] d;
        wb_write(R_LOAD, 32'h1234, 4'hF);
        wb_write(R_CTRL, 32'h6, 4'hF);
        @(posedge clk); #1;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0;
        i_wb_addr = {27'd0, R_LOAD, 2'b00}; i_wb_sel = 4'hF;
        @(posedge clk); #1;
        total++;
        if (o_wb_ack !== 1'b1) begin bad++; $display("FAIL midrst_pre_ack got=%b want=1", o_wb_ack); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if (o_wb_ack !== 1'b0) begin bad++; $display("FAIL midrst_ack got=%b want=0", o_wb_ack); end
        total++;
        if (o_wb_data !== 32'd0) begin bad++; $display("FAIL midrst_data got=%h want=0", o_wb_data); end
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        rst_n = 1'b1;
        wb_read(R_LOAD, d);
        total++;
        if (d !== 32'd0) begin bad++; $display("FAIL midrst_load got=%h want=0", d); end
        wb_read(R_CTRL, d);
        total++;
        if (d !== 32'd0) begin bad++; $display("FAIL midrst_ctrl got=%h want=0", d); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst_n     = 1'b0;
        i_wb_cyc  = 1'b0;
        i_wb_stb  = 1'b0;
        i_wb_we   = 1'b0;
        i_wb_addr = 32'd0;
        i_wb_data = 32'd0;
        i_wb_sel  = 4'h0;
        i_eoi     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        test_reset();
        test_back_to_back();
        test_cyc_drop();
        test_sel();
        test_random_regs();
        test_autoreload();
        test_random_periodic();
        test_oneshot();
        test_clear();
        test_collisions();
`ifdef WB_TIMER_PWM_EN
        test_pwm();
`endif
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
